// File: rtl/hydra_pkg.sv
// Shared widths and state encodings for the per-port SRAM matchers.
package hydra_pkg;

  localparam int unsigned SRAM_NUM   = 32;
  localparam int unsigned SRAM_IDX_W = 5;
  localparam int unsigned TS_W       = 8;
  localparam int unsigned AMOUNT_W   = 9;
  localparam int unsigned TICK_W     = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } rd_match_state_t;

endpackage

// File: rtl/port_rd_sram_matcher.sv
// Read-side SRAM matcher: scans rotator status one SRAM per cycle and picks the
// accessible SRAM holding this port's oldest head packet.
module port_rd_sram_matcher
  import hydra_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [TICK_W-1:0]     match_threshold,
  input  logic                  match_enable,
  output logic                  match_suc,
  input  logic [SRAM_IDX_W-1:0] matching_sram,
  input  logic                  accessible,
  input  logic [AMOUNT_W-1:0]   packet_amount,
  input  logic [TS_W-1:0]       head_timestamp,
  input  logic [TS_W-1:0]       current_time,
  output logic [SRAM_IDX_W-1:0] matching_best_sram,
  output logic [TS_W-1:0]       best_age,
  output logic                  update_matched_sram
);

  rd_match_state_t       state_q, state_d;
  logic                  find_q, find_d;
  logic                  suc_q, suc_d;
  logic [TICK_W-1:0]     tick_q, tick_d;
  logic [SRAM_IDX_W-1:0] best_q, best_d;
  logic [TS_W-1:0]       best_age_q, best_age_d;

  logic [TS_W-1:0]       age;
  logic                  candidate;
  logic                  is_best;

  always_comb begin
    // Modulo-256 subtraction keeps ages correct across time wrap-around.
    age        = current_time - head_timestamp;
    candidate  = accessible && (packet_amount != '0);
    is_best    = (matching_sram == best_q);

    state_d    = state_q;
    find_d     = find_q;
    suc_d      = 1'b0;
    tick_d     = '0;
    best_d     = best_q;
    best_age_d = best_age_q;

    unique case (state_q)
      IDLE: begin
        if (match_enable) state_d = SCAN;
      end
      SCAN: begin
        if (!match_enable) begin
          state_d    = IDLE;
          find_d     = 1'b0;
          best_age_d = '0;
        end else begin
          tick_d = (tick_q == match_threshold) ? tick_q : tick_q + 1'b1;
          if (find_q && (tick_q == match_threshold)) begin
            state_d = DONE;
            suc_d   = 1'b1;
          end
          if (candidate && ((age >= best_age_q) || is_best)) begin
            best_d     = matching_sram;
            best_age_d = age;
            find_d     = 1'b1;
          end else if (!candidate && is_best && find_q) begin
            find_d     = 1'b0;
            best_age_d = '0;
          end
        end
      end
      DONE: begin
        state_d    = IDLE;
        find_d     = 1'b0;
        best_age_d = '0;
      end
      default: begin
        state_d    = IDLE;
        find_d     = 1'b0;
        best_age_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      find_q     <= 1'b0;
      suc_q      <= 1'b0;
      tick_q     <= '0;
      best_q     <= '0;
      best_age_q <= '0;
    end else begin
      state_q    <= state_d;
      find_q     <= find_d;
      suc_q      <= suc_d;
      tick_q     <= tick_d;
      best_q     <= best_d;
      best_age_q <= best_age_d;
    end
  end

  assign match_suc           = suc_q;
  assign matching_best_sram  = best_q;
  assign best_age            = best_age_q;
  assign update_matched_sram = (state_q == SCAN) && find_q;

endmodule

// File: tb/tb_port_rd_sram_matcher.sv
// Directed bench for port_rd_sram_matcher with hand-derived cycle expectations.
module tb_port_rd_sram_matcher;
  import hydra_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b1;
  logic [TICK_W-1:0]     match_threshold = '0;
  logic                  match_enable = 1'b0;
  logic                  match_suc;
  logic [SRAM_IDX_W-1:0] matching_sram = '1;
  logic                  accessible = 1'b0;
  logic [AMOUNT_W-1:0]   packet_amount = '0;
  logic [TS_W-1:0]       head_timestamp = '0;
  logic [TS_W-1:0]       current_time = '0;
  logic [SRAM_IDX_W-1:0] matching_best_sram;
  logic [TS_W-1:0]       best_age;
  logic                  update_matched_sram;

  int tests = 0;
  int fails = 0;

  port_rd_sram_matcher dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .match_threshold     (match_threshold),
    .match_enable        (match_enable),
    .match_suc           (match_suc),
    .matching_sram       (matching_sram),
    .accessible          (accessible),
    .packet_amount       (packet_amount),
    .head_timestamp      (head_timestamp),
    .current_time        (current_time),
    .matching_best_sram  (matching_best_sram),
    .best_age            (best_age),
    .update_matched_sram (update_matched_sram)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sram, input int acc, input int amt, input int ts);
    matching_sram  = sram[SRAM_IDX_W-1:0];
    accessible     = acc[0];
    packet_amount  = amt[AMOUNT_W-1:0];
    head_timestamp = ts[TS_W-1:0];
  endtask

  task automatic idle_in();
    drive(31, 0, 0, 0);
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    tests++; if (match_suc !== 1'b0) begin fails++; $display("FAIL reset_suc: got %0b want 0", match_suc); end
    tests++; if (matching_best_sram !== 5'd0) begin fails++; $display("FAIL reset_best: got %0d want 0", matching_best_sram); end
    tests++; if (best_age !== 8'd0) begin fails++; $display("FAIL reset_age: got %0d want 0", best_age); end
    tests++; if (update_matched_sram !== 1'b0) begin fails++; $display("FAIL reset_upd: got %0b want 0", update_matched_sram); end
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_wrap_age();
    match_threshold = 5'd3; current_time = 8'd4; idle_in();
    match_enable = 1'b1;
    step();
    drive(3, 1, 1, 250); step();
    tests++; if (update_matched_sram !== 1'b1) begin fails++; $display("FAIL wrap_upd: got %0b want 1", update_matched_sram); end
    tests++; if (best_age !== 8'd10) begin fails++; $display("FAIL wrap_age1: got %0d want 10", best_age); end
    drive(7, 1, 2, 0); step();
    tests++; if (matching_best_sram !== 5'd3) begin fails++; $display("FAIL wrap_best_hold: got %0d want 3", matching_best_sram); end
    idle_in(); step();
    tests++; if (match_suc !== 1'b0) begin fails++; $display("FAIL wrap_early_suc: got %0b want 0", match_suc); end
    step();
    tests++; if (match_suc !== 1'b1) begin fails++; $display("FAIL wrap_suc: got %0b want 1", match_suc); end
    tests++; if (matching_best_sram !== 5'd3) begin fails++; $display("FAIL wrap_best: got %0d want 3", matching_best_sram); end
    tests++; if (best_age !== 8'd10) begin fails++; $display("FAIL wrap_age: got %0d want 10", best_age); end
    match_enable = 1'b0; step();
    tests++; if (match_suc !== 1'b0) begin fails++; $display("FAIL wrap_suc_width: got %0b want 0", match_suc); end
    tests++; if (best_age !== 8'd0) begin fails++; $display("FAIL wrap_age_cleared: got %0d want 0", best_age); end
    step();
  endtask

  task automatic test_tie_refresh();
    match_threshold = 5'd5; current_time = 8'd100; idle_in();
    match_enable = 1'b1;
    step();
    drive(5, 1, 3, 90); step();
    drive(9, 1, 1, 90); step();
    tests++; if (matching_best_sram !== 5'd9) begin fails++; $display("FAIL tie_best: got %0d want 9", matching_best_sram); end
    current_time = 8'd101; drive(9, 1, 1, 90); step();
    tests++; if (best_age !== 8'd11) begin fails++; $display("FAIL refresh_age: got %0d want 11", best_age); end
    tests++; if (matching_best_sram !== 5'd9) begin fails++; $display("FAIL refresh_best: got %0d want 9", matching_best_sram); end
    idle_in(); step(); step();
    tests++; if (match_suc !== 1'b0) begin fails++; $display("FAIL tie_early_suc: got %0b want 0", match_suc); end
    step();
    tests++; if (match_suc !== 1'b1) begin fails++; $display("FAIL tie_suc: got %0b want 1", match_suc); end
    tests++; if (matching_best_sram !== 5'd9) begin fails++; $display("FAIL tie_best_at_suc: got %0d want 9", matching_best_sram); end
    match_enable = 1'b0; step(); step();
  endtask

  task automatic test_stale_best();
    match_threshold = 5'd4; current_time = 8'd50; idle_in();
    match_enable = 1'b1;
    step();
    drive(2, 1, 1, 45); step();
    tests++; if (matching_best_sram !== 5'd2) begin fails++; $display("FAIL stale_best_first: got %0d want 2", matching_best_sram); end
    drive(2, 1, 0, 45); step();
    tests++; if (update_matched_sram !== 1'b0) begin fails++; $display("FAIL stale_upd: got %0b want 0", update_matched_sram); end
    tests++; if (best_age !== 8'd0) begin fails++; $display("FAIL stale_age: got %0d want 0", best_age); end
    idle_in(); step(); step();
    tests++; if (match_suc !== 1'b0) begin fails++; $display("FAIL stale_no_suc: got %0b want 0", match_suc); end
    drive(6, 1, 4, 43); step();
    tests++; if (update_matched_sram !== 1'b1) begin fails++; $display("FAIL stale_upd_new: got %0b want 1", update_matched_sram); end
    tests++; if (best_age !== 8'd7) begin fails++; $display("FAIL stale_age_new: got %0d want 7", best_age); end
    idle_in(); step();
    tests++; if (match_suc !== 1'b1) begin fails++; $display("FAIL stale_suc: got %0b want 1", match_suc); end
    tests++; if (matching_best_sram !== 5'd6) begin fails++; $display("FAIL stale_best_new: got %0d want 6", matching_best_sram); end
    match_enable = 1'b0; step(); step();
  endtask

  task automatic test_nothing_available();
    int seen;
    seen = 0;
    match_threshold = 5'd4; current_time = 8'd200; idle_in();
    match_enable = 1'b1;
    step();
    for (int i = 0; i < 40; i++) begin
      drive(i % 32, i % 2, (i % 2 == 1) ? 0 : 5, 100);
      step();
      if (match_suc === 1'b1) seen++;
    end
    tests++; if (seen !== 0) begin fails++; $display("FAIL none_suc_count: got %0d want 0", seen); end
    tests++; if (update_matched_sram !== 1'b0) begin fails++; $display("FAIL none_upd: got %0b want 0", update_matched_sram); end
    drive(12, 1, 1, 190); step();
    tests++; if (match_suc !== 1'b0) begin fails++; $display("FAIL none_cand_suc: got %0b want 0", match_suc); end
    idle_in(); step();
    tests++; if (match_suc !== 1'b1) begin fails++; $display("FAIL none_late_suc: got %0b want 1", match_suc); end
    tests++; if (matching_best_sram !== 5'd12) begin fails++; $display("FAIL none_best: got %0d want 12", matching_best_sram); end
    tests++; if (best_age !== 8'd10) begin fails++; $display("FAIL none_age: got %0d want 10", best_age); end
    match_enable = 1'b0; step(); step();
  endtask

  task automatic test_abort_reset();
    int seen;
    seen = 0;
    match_threshold = 5'd6; current_time = 8'd30; idle_in();
    match_enable = 1'b1;
    step();
    drive(4, 1, 1, 20); step();
    tests++; if (best_age !== 8'd10) begin fails++; $display("FAIL abort_age_pre: got %0d want 10", best_age); end
    match_enable = 1'b0; idle_in(); step();
    tests++; if (update_matched_sram !== 1'b0) begin fails++; $display("FAIL abort_upd: got %0b want 0", update_matched_sram); end
    tests++; if (best_age !== 8'd0) begin fails++; $display("FAIL abort_age: got %0d want 0", best_age); end
    for (int i = 0; i < 8; i++) begin
      step();
      if (match_suc === 1'b1) seen++;
    end
    tests++; if (seen !== 0) begin fails++; $display("FAIL abort_suc_count: got %0d want 0", seen); end
    match_enable = 1'b1;
    step();
    drive(8, 1, 1, 10); step();
    tests++; if (matching_best_sram !== 5'd8) begin fails++; $display("FAIL rst_pre_best: got %0d want 8", matching_best_sram); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (matching_best_sram !== 5'd0) begin fails++; $display("FAIL rst_best: got %0d want 0", matching_best_sram); end
    tests++; if (best_age !== 8'd0) begin fails++; $display("FAIL rst_age: got %0d want 0", best_age); end
    tests++; if (update_matched_sram !== 1'b0) begin fails++; $display("FAIL rst_upd: got %0b want 0", update_matched_sram); end
    tests++; if (match_suc !== 1'b0) begin fails++; $display("FAIL rst_suc: got %0b want 0", match_suc); end
    match_enable = 1'b0; idle_in();
    #2 rst_n = 1'b1;
    step(); step();
  endtask

  task automatic test_back_to_back();
    int nsuc, t1, t2, b1, b2, a1, a2;
    nsuc = 0; t1 = 0; t2 = 0; b1 = 0; b2 = 0; a1 = 0; a2 = 0;
    match_threshold = 5'd2; current_time = 8'd60;
    match_enable = 1'b1;
    for (int i = 0; i < 30 && nsuc < 2; i++) begin
      if (nsuc == 0) drive(10, 1, 1, 55);
      else           drive(20, 1, 1, 30);
      step();
      if (match_suc === 1'b1) begin
        if (nsuc == 0) begin t1 = i; b1 = int'(matching_best_sram); a1 = int'(best_age); end
        else           begin t2 = i; b2 = int'(matching_best_sram); a2 = int'(best_age); end
        nsuc++;
      end
    end
    match_enable = 1'b0; idle_in();
    tests++; if (nsuc !== 2) begin fails++; $display("FAIL b2b_count: got %0d want 2", nsuc); end
    tests++; if (b1 !== 10 || a1 !== 5) begin fails++; $display("FAIL b2b_first: got sram %0d age %0d want sram 10 age 5", b1, a1); end
    tests++; if (b2 !== 20 || a2 !== 30) begin fails++; $display("FAIL b2b_second: got sram %0d age %0d want sram 20 age 30", b2, a2); end
    tests++; if (t2 - t1 !== 5) begin fails++; $display("FAIL b2b_gap: got %0d want 5", t2 - t1); end
    step();
    tests++; if (match_suc !== 1'b0) begin fails++; $display("FAIL b2b_pulse_width: got %0b want 0", match_suc); end
    step();
  endtask

  initial begin
    test_reset();
    test_wrap_age();
    test_tie_refresh();
    test_stale_best();
    test_nothing_available();
    test_abort_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/port_rd_sram_matcher.md
# port_rd_sram_matcher

Read-side counterpart of the per-port write SRAM matcher. When an output port requests its next packet, it scans the SRAM status presented by the back-end rotator one SRAM per cycle. It selects the accessible SRAM whose queued head packet for this port is oldest, then reports the chosen SRAM after a configurable dwell time. One instance sits in each output port's read path, between the port's dequeue FSM and the SRAM read arbiter.

## Interface
- Parameters: none. Widths come from the shared package.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `match_threshold` in 5: minimum scan ticks before success is allowed.
- `match_enable` in 1: read request from the dequeue FSM. Held high until `match_suc`.
- `match_suc` out 1: one-cycle pulse; `matching_best_sram` is valid in this cycle.
- `matching_sram` in 5: index of the SRAM whose status is on the inputs this cycle.
- `accessible` in 1: that SRAM is not blocked by another reader.
- `packet_amount` in 9: packets for this port queued in that SRAM.
- `head_timestamp` in 8: enqueue time of that SRAM's head packet for this port.
- `current_time` in 8: free-running global time, wraps modulo 256.
- `matching_best_sram` out 5: current best candidate.
- `best_age` out 8: age of the current best candidate.
- `update_matched_sram` out 1: candidate-valid indication to the back end.

## Operation
- **FSM states.**
  - IDLE→SCAN when `match_enable` is high.
  - SCAN→DONE when `find` is set and `tick == match_threshold`.
  - SCAN→IDLE when `match_enable` goes low (abort).
  - DONE→IDLE always, after one cycle.
- **Age.** `age = (current_time - head_timestamp) mod 256`, computed as 8-bit unsigned wrap-around subtraction. A timestamp of 250 at time 4 gives age 10.
- **Candidate.** In SCAN, an SRAM is a candidate when `accessible` is high and `packet_amount != 0`.
- **Update rule (SCAN only), evaluated each cycle:**
  - Candidate with `age >= best_age`, or candidate with `matching_sram == matching_best_sram`: load `matching_best_sram`, `best_age` and set `find`. Ties go to the most recently scanned SRAM.
  - Non-candidate with `matching_sram == matching_best_sram` while `find` is set: clear `find` and zero `best_age`. The stale best is dropped.
  - Otherwise: hold.
- **Tick counter (5-bit).**
  - Cleared to 0 in IDLE and DONE.
  - In SCAN, increments each cycle and saturates at `match_threshold`.
  - If `find` is still 0 when the threshold is reached, the block keeps scanning. It succeeds in the first cycle with `find` set, with no timeout.
- **Clearing.** `find`, `best_age` and `tick` are cleared when entering IDLE from DONE or from an abort.
- **`update_matched_sram`** is combinational: `(state == SCAN) && find`.

## Timing
- **Reset values:**
  - state IDLE
  - `match_suc` 0
  - `matching_best_sram` 0
  - `best_age` 0
  - `find` 0
  - `tick` 0
- **Request start.** With `match_enable` rising at edge N, the state is SCAN from N+1 and status sampling begins at edge N+2. Inputs at edge N+1 are ignored.
- **Success latency.**
  - The DONE condition is registered, so `match_suc` is high for exactly one cycle, one cycle after the condition.
  - Minimum request-to-`match_suc` is `match_threshold + 2` cycles.
  - `match_threshold == 0`: success in the cycle after the first `find`.
- **Outputs stable.** `matching_best_sram` and `best_age` do not change in the `match_suc` cycle.
- **Back-to-back requests.** If `match_enable` stays high through DONE, a new scan starts from a cleared candidate, one cycle after IDLE.
- **Abort.** `match_enable` low during SCAN returns the block to IDLE with no `match_suc`.
- **Mid-operation reset.** Reset at any time forces all reset values immediately.

## Structure
- **Shared package `hydra_pkg`:**
  - `SRAM_NUM = 32`
  - `SRAM_IDX_W = 5`
  - `TS_W = 8`
  - `AMOUNT_W = 9`
  - `TICK_W = 5`
  - Enum `rd_match_state_t` {IDLE, SCAN, DONE}
- **Sub-modules:** none. The age subtract-and-compare is a few lines inline.

## Test plan
- **Wrap-around age.** `current_time = 4`; SRAMs 3 and 7 offered with timestamps 250 and 0 (ages 10 and 4), `threshold = 3`. Expect `best = 3`, `best_age = 10`, and `match_suc` at request+5.
- **Tie and refresh.** SRAMs 5 and 9 offered with equal age. Expect best 9. SRAM 9 revisited one tick older: `best_age` increments, best stays 9.
- **Stale best.** Best is SRAM 2; SRAM 2 revisited with `packet_amount = 0`. Expect `find` cleared and `update_matched_sram` low. A later SRAM 6 candidate gives best 6 and success.
- **Nothing available.** All SRAMs inaccessible for 40 cycles with `threshold = 4`. Expect no `match_suc`. First candidate at cycle 41 gives `match_suc` the next cycle.
- **Abort, then reset.** Drop `match_enable` during SCAN: IDLE, no pulse, `best_age = 0`. Pulse `rst_n` low mid-scan: all outputs read 0 asynchronously.
- **Back-to-back.** Hold `match_enable` high across two successes. Expect two single-cycle `match_suc` pulses separated by at least `threshold + 3` cycles, the second with a freshly selected SRAM.
